// File: rtl/alu_pkg.sv
// Shared opcodes, result constants and controller state encoding.
package alu_pkg;

  localparam logic [7:0]  OP_ADD     = 8'h10;
  localparam logic [7:0]  OP_MUL     = 8'h11;
  localparam logic [31:0] ERR_RESULT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    StIdle,
    StRsvd,
    StLenLo,
    StLenHi,
    StOpnd,
    StExec,
    StResp
  } state_e;

endpackage

// File: rtl/alu_packet_ctrl_if.sv
// Start/done handshake between the packet controller and the iterative multiplier.
interface alu_packet_ctrl_if;

  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        done;
  logic [31:0] product;

  modport master (
    output start,
    output op_a,
    output op_b,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  op_a,
    input  op_b,
    output done,
    output product
  );

endinterface

// File: rtl/iter_mul32.sv
// 32-cycle shift-add multiplier returning the low 32 bits of the product.
// The first step works directly on the start operands, so the result is
// available (done high) in the 32nd cycle counted from the start cycle.
module iter_mul32
  import alu_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  alu_packet_ctrl_if.slave mul
);

  logic        busy_q, busy_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] a_cur, b_cur, acc_cur, acc_sum;

  // Operand view for the current step: live inputs on the start cycle, registers afterwards.
  assign a_cur   = busy_q ? a_q : mul.op_a;
  assign b_cur   = busy_q ? b_q : mul.op_b;
  assign acc_cur = busy_q ? acc_q : 32'h0;
  assign acc_sum = acc_cur + (b_cur[0] ? a_cur : 32'h0);

  assign mul.done    = busy_q && (cnt_q == 5'd31);
  assign mul.product = acc_sum;

  // One shift-add step per cycle while running; start is ignored while busy.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    if (busy_q || mul.start) begin
      a_d    = a_cur << 1;
      b_d    = b_cur >> 1;
      acc_d  = acc_sum;
      cnt_d  = busy_q ? cnt_q + 5'd1 : 5'd1;
      busy_d = !(busy_q && (cnt_q == 5'd31));
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/alu_packet_ctrl.sv
// Byte-stream packet ALU: receives opcode/length/operands from a UART
// receiver, folds the operands into an accumulator and returns the 32-bit
// result as four little-endian bytes.
module alu_packet_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       busy_o,
  output logic       err_o
);

  localparam int unsigned   TmoW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [7:0]      opcode_q, opcode_d;
  logic [7:0]      len_lo_q, len_lo_d;
  logic [15:0]     left_q, left_d;
  logic            first_q, first_d;
  logic [1:0]      byte_q, byte_d;
  logic [31:0]     opnd_q, opnd_d;
  logic [31:0]     acc_q, acc_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            err_q, err_d;
  logic            rdy_q;

  logic rx_hs, tx_hs, wait_st, op_known, exec_done;

  alu_packet_ctrl_if mul_bus ();

  iter_mul32 u_mul (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .mul    (mul_bus)
  );

  // Only non-first multiply operands go through the iterative multiplier.
  assign mul_bus.start = (state_q == StExec) && !first_q && (opcode_q == OP_MUL);
  assign mul_bus.op_a  = acc_q;
  assign mul_bus.op_b  = opnd_q;

  // rdy_q keeps rx_ready_o low until the first clock after reset release.
  assign rx_ready_o = rdy_q && (state_q inside {StIdle, StRsvd, StLenLo, StLenHi, StOpnd});
  assign tx_valid_o = (state_q == StResp);
  assign tx_data_o  = (state_q == StResp) ? acc_q[{byte_q, 3'b000} +: 8] : 8'h00;
  assign busy_o     = (state_q != StIdle);
  assign err_o      = err_q;

  assign rx_hs    = rx_valid_i && rx_ready_o;
  assign tx_hs    = tx_valid_o && tx_ready_i;
  assign wait_st  = state_q inside {StRsvd, StLenLo, StLenHi, StOpnd};
  assign op_known = (opcode_q == OP_ADD) || (opcode_q == OP_MUL);

  // Next-state, datapath and inter-byte timeout.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    len_lo_d  = len_lo_q;
    left_d    = left_q;
    first_d   = first_q;
    byte_d    = byte_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    err_d     = 1'b0;
    exec_done = 1'b0;
    tmo_d     = '0;
    if (wait_st && !rx_hs) begin
      tmo_d = tmo_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (rx_hs) begin
          opcode_d = rx_data_i;
          state_d  = StRsvd;
        end
      end
      StRsvd: begin
        if (rx_hs) begin
          state_d = StLenLo;
        end
      end
      StLenLo: begin
        if (rx_hs) begin
          len_lo_d = rx_data_i;
          state_d  = StLenHi;
        end
      end
      StLenHi: begin
        if (rx_hs) begin
          left_d  = {rx_data_i, len_lo_q};
          first_d = 1'b1;
          byte_d  = '0;
          if ({rx_data_i, len_lo_q} == 16'd0) begin
            acc_d   = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            err_d   = !op_known;
            state_d = StOpnd;
          end
        end
      end
      StOpnd: begin
        if (rx_hs) begin
          opnd_d = {rx_data_i, opnd_q[31:8]};
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            state_d = StExec;
          end
        end
      end
      StExec: begin
        exec_done = 1'b1;
        if (!op_known) begin
          acc_d = ERR_RESULT;
        end else if (first_q) begin
          acc_d = opnd_q;
        end else if (opcode_q == OP_ADD) begin
          acc_d = acc_q + opnd_q;
        end else begin
          exec_done = mul_bus.done;
          if (mul_bus.done) begin
            acc_d = mul_bus.product;
          end
        end
        if (exec_done) begin
          first_d = 1'b0;
          left_d  = left_q - 16'd1;
          state_d = (left_q == 16'd1) ? StResp : StOpnd;
        end
      end
      StResp: begin
        if (tx_hs) begin
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Stalled sender: abandon the packet without a response.
    if (wait_st && !rx_hs && (tmo_q == TmoLast)) begin
      state_d = StIdle;
      tmo_d   = '0;
      err_d   = 1'b1;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      opcode_q <= '0;
      len_lo_q <= '0;
      left_q   <= '0;
      first_q  <= 1'b0;
      byte_q   <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      len_lo_q <= len_lo_d;
      left_q   <= left_d;
      first_q  <= first_d;
      byte_q   <= byte_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      rdy_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_packet_ctrl.sv
// Directed bench for alu_packet_ctrl: one task per scenario, inline checks.
module tb_alu_packet_ctrl;

  localparam int unsigned Tmo = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_fail = 0;
  int err_cnt = 0;
  logic [7:0] tx_q[$];

  always #5 clk = ~clk;

  alu_packet_ctrl #(
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .busy_o     (busy),
    .err_o      (err)
  );

  // Capture transmitted bytes and error pulses.
  always @(posedge clk) begin
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (err) err_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    int w;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    w = 0;
    while (!rx_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!rx_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_accept: rx_ready=%0b required 1", rx_ready);
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] op, input logic [15:0] n,
                             input logic [31:0] o0, input logic [31:0] o1,
                             input logic [31:0] o2);
    logic [31:0] ops[3];
    ops[0] = o0;
    ops[1] = o1;
    ops[2] = o2;
    send_byte(op);
    send_byte(8'hA5);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int i = 0; i < int'(n) && i < 3; i++) begin
      for (int k = 0; k < 4; k++) send_byte(ops[i][8*k +: 8]);
    end
  endtask

  task automatic wait_resp();
    int w;
    w = 0;
    while (tx_q.size() < 4 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (tx_q.size() < 4) begin
      n_checks++;
      n_fail++;
      $display("FAIL resp_timeout: got %0d bytes required 4", tx_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic count_to_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!tx_valid && cyc < 300);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rx_ready: got %0b required 0", rx_ready); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %0b required 0", tx_valid); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h required 00", tx_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b required 0", busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b required 0", err); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %0b required 1", rx_ready); end
  endtask

  task automatic test_add();
    logic [31:0] exp;
    int cyc;
    tx_q = {};
    err_cnt = 0;
    exp = 32'h0000_0003;
    send_packet(8'h10, 16'd2, 32'd1, 32'd2, 32'd0);
    count_to_valid(cyc);
    n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL add_latency: got %0d required 2", cyc); end
    wait_resp();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tx_q.size() <= i || tx_q[i] !== exp[8*i +: 8]) begin
        n_fail++;
        $display("FAIL add_byte%0d: got %h required %h", i, (tx_q.size() > i) ? tx_q[i] : 8'hxx, exp[8*i +: 8]);
      end
    end
    n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL add_err: got %0d pulses required 0", err_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL add_idle: busy=%0b required 0", busy); end
  endtask

  task automatic test_mul();
    logic [31:0] exp;
    int cyc;
    tx_q = {};
    err_cnt = 0;
    exp = 32'h0000_001E;
    send_packet(8'h11, 16'd2, 32'd5, 32'd6, 32'd0);
    // 1 EXEC cycle for operand 1 happens before the last byte; 32 for operand 2.
    count_to_valid(cyc);
    n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL mul_latency: got %0d required 33", cyc); end
    wait_resp();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tx_q.size() <= i || tx_q[i] !== exp[8*i +: 8]) begin
        n_fail++;
        $display("FAIL mul_byte%0d: got %h required %h", i, (tx_q.size() > i) ? tx_q[i] : 8'hxx, exp[8*i +: 8]);
      end
    end
    tx_q = {};
    exp = 32'h0000_0000;
    send_packet(8'h11, 16'd2, 32'h0001_0000, 32'h0001_0000, 32'd0);
    wait_resp();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tx_q.size() <= i || tx_q[i] !== exp[8*i +: 8]) begin
        n_fail++;
        $display("FAIL mul_wrap_byte%0d: got %h required %h", i, (tx_q.size() > i) ? tx_q[i] : 8'hxx, exp[8*i +: 8]);
      end
    end
    n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL mul_err: got %0d pulses required 0", err_cnt); end
  endtask

  task automatic test_bad_op();
    int cyc;
    tx_q = {};
    err_cnt = 0;
    send_packet(8'h22, 16'd2, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);
    wait_resp();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tx_q.size() <= i || tx_q[i] !== 8'hFF) begin
        n_fail++;
        $display("FAIL badop_byte%0d: got %h required ff", i, (tx_q.size() > i) ? tx_q[i] : 8'hxx);
      end
    end
    n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL badop_err: got %0d pulses required 1", err_cnt); end
    // Zero-length packet: straight to response with result 0.
    tx_q = {};
    err_cnt = 0;
    send_packet(8'h10, 16'd0, 32'd0, 32'd0, 32'd0);
    count_to_valid(cyc);
    n_checks++; if (cyc != 1) begin n_fail++; $display("FAIL zero_latency: got %0d required 1", cyc); end
    wait_resp();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tx_q.size() <= i || tx_q[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL zero_byte%0d: got %h required 00", i, (tx_q.size() > i) ? tx_q[i] : 8'hxx);
      end
    end
    n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL zero_err: got %0d pulses required 1", err_cnt); end
  endtask

  task automatic test_stall();
    logic [31:0] exp;
    int w;
    tx_q = {};
    err_cnt = 0;
    exp = 32'h0000_0005;
    tx_ready = 1'b0;
    send_packet(8'h10, 16'd3, 32'hFFFF_FFFF, 32'd1, 32'd5);
    for (int i = 0; i < 4; i++) begin
      w = 0;
      while (!tx_valid && w < 300) begin
        @(negedge clk);
        w++;
      end
      for (int s = 0; s < 10; s++) begin
        @(negedge clk);
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== exp[8*i +: 8]) begin
          n_fail++;
          $display("FAIL stall_byte%0d_cyc%0d: got valid=%0b data=%h required 1 %h", i, s, tx_valid, tx_data, exp[8*i +: 8]);
        end
      end
      tx_ready = 1'b1;
      @(posedge clk);
      #1 tx_ready = 1'b0;
    end
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (tx_q.size() != 4) begin n_fail++; $display("FAIL stall_count: got %0d bytes required 4", tx_q.size()); end
    n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL stall_err: got %0d pulses required 0", err_cnt); end
  endtask

  task automatic test_timeout();
    tx_q = {};
    err_cnt = 0;
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    repeat (Tmo + 10) @(negedge clk);
    n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL tmo_err: got %0d pulses required 1", err_cnt); end
    n_checks++; if (tx_q.size() != 0) begin n_fail++; $display("FAIL tmo_tx: got %0d bytes required 0", tx_q.size()); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %0b required 0", busy); end
    err_cnt = 0;
    send_packet(8'h10, 16'd2, 32'd1, 32'd2, 32'd0);
    wait_resp();
    n_checks++;
    if (tx_q.size() != 4 || tx_q[0] !== 8'h03 || tx_q[1] !== 8'h00 || tx_q[2] !== 8'h00 || tx_q[3] !== 8'h00) begin
      n_fail++;
      $display("FAIL tmo_recover: got %0d bytes first=%h required 4 bytes 03 00 00 00", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_reset_mid_exec();
    tx_q = {};
    err_cnt = 0;
    send_packet(8'h11, 16'd2, 32'h0000_0123, 32'h0000_0456, 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rx_ready !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got ready=%0b valid=%0b data=%h busy=%0b err=%0b required 0 0 00 0 0", rx_ready, tx_valid, tx_data, busy, err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    n_checks++; if (tx_q.size() != 0) begin n_fail++; $display("FAIL midrst_tx: got %0d bytes required 0", tx_q.size()); end
    send_packet(8'h10, 16'd2, 32'd1, 32'd2, 32'd0);
    wait_resp();
    n_checks++;
    if (tx_q.size() != 4 || tx_q[0] !== 8'h03 || tx_q[1] !== 8'h00 || tx_q[2] !== 8'h00 || tx_q[3] !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_recover: got %0d bytes first=%h required 4 bytes 03 00 00 00", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp0, exp1;
    tx_q = {};
    err_cnt = 0;
    exp0 = 32'd42;          // 3 * 7 * 2
    exp1 = 32'h2345_6789;   // 0x12345678 + 0x11111111
    send_packet(8'h11, 16'd3, 32'd3, 32'd7, 32'd2);
    send_packet(8'h10, 16'd2, 32'h1234_5678, 32'h1111_1111, 32'd0);
    wait_resp();
    repeat (80) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tx_q.size() <= i || tx_q[i] !== exp0[8*i +: 8]) begin
        n_fail++;
        $display("FAIL b2b0_byte%0d: got %h required %h", i, (tx_q.size() > i) ? tx_q[i] : 8'hxx, exp0[8*i +: 8]);
      end
      n_checks++;
      if (tx_q.size() <= i + 4 || tx_q[i+4] !== exp1[8*i +: 8]) begin
        n_fail++;
        $display("FAIL b2b1_byte%0d: got %h required %h", i, (tx_q.size() > i + 4) ? tx_q[i+4] : 8'hxx, exp1[8*i +: 8]);
      end
    end
    n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL b2b_err: got %0d pulses required 0", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_bad_op();
    test_stall();
    test_timeout();
    test_reset_mid_exec();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_packet_ctrl.md
ALU_PACKET_CTRL -- requirements
Module: alu_packet_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning idle cycles allowed between received bytes of one packet.
REQ-002 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx_data_i  input  8  byte from UART receiver.
REQ-005 SHALL have port rx_valid_i  input  1  rx_data_i valid.
REQ-006 SHALL have port rx_ready_o  output  1  controller accepts byte; handshake when rx_valid_i & rx_ready_o.
REQ-007 SHALL have port tx_data_o  output  8  result byte to UART transmitter.
REQ-008 SHALL have port tx_valid_o  output  1  tx_data_o valid.
REQ-009 SHALL have port tx_ready_i  input  1  transmitter accepts byte.
REQ-010 SHALL have port busy_o  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port err_o  output  1  one-cycle pulse on protocol error.

Function
REQ-012 Packet SHALL be: opcode byte, reserved byte (ignored), length LSB, length MSB (operand count N, 16 bit), then N 32-bit operands, each little-endian (LSB first).
REQ-013 States SHALL be IDLE, RSVD, LEN_LO, LEN_HI, OPND, EXEC, RESP; IDLE->RSVD->LEN_LO->LEN_HI on each rx handshake.
REQ-014 LEN_HI handshake SHALL go to OPND if N>0, else to RESP with result 0 and err_o pulse.
REQ-015 OPND SHALL collect 4 bytes, then go to EXEC; rx_ready_o SHALL be high only in IDLE, RSVD, LEN_LO, LEN_HI, OPND.
REQ-016 Operand 1 SHALL load accumulator directly for every opcode (1 EXEC cycle).
REQ-017 Opcode 8'h10: each later operand SHALL be added to accumulator modulo 2^32 in exactly 1 EXEC cycle.
REQ-018 Opcode 8'h11: each later operand SHALL multiply accumulator, keeping low 32 bits, in exactly 32 EXEC cycles (shift-add).
REQ-019 Any other opcode: operands SHALL be consumed and discarded, result SHALL be 32'hFFFF_FFFF, err_o SHALL pulse once at LEN_HI handshake.
REQ-020 EXEC SHALL return to OPND while operands remain, else go to RESP; tx_valid_o SHALL rise the cycle after the final EXEC cycle.
REQ-021 RESP SHALL emit 4 result bytes LSB first; tx_data_o SHALL stay stable while tx_valid_o & !tx_ready_i.
REQ-022 After the 4th tx handshake state SHALL go to IDLE; next packet opcode may be accepted the following cycle.
REQ-023 Inter-byte counter SHALL clear on every rx handshake and in IDLE, EXEC, RESP; reaching TIMEOUT_CYCLES in RSVD..OPND SHALL go to IDLE, pulse err_o, emit no response.
REQ-024 N=65535 SHALL be processed without counter wrap (17-bit or decrementing count).

Reset
REQ-025 On rst_ni low (any state, including mid-EXEC or mid-RESP): state IDLE, accumulator 0, counters 0, rx_ready_o 0, tx_valid_o 0, tx_data_o 0, busy_o 0, err_o 0; rx_ready_o SHALL go high the first cycle after release.
REQ-026 A partially received or transmitted packet SHALL be dropped on reset; no byte from it appears afterwards.

Structure
REQ-027 Package alu_pkg SHALL hold OP_ADD=8'h10, OP_MUL=8'h11, ERR_RESULT=32'hFFFF_FFFF, and the state enum typedef.
REQ-028 Multiplier SHALL be sub-module iter_mul32 (start/done handshake, 32-cycle shift-add, low-32 product).

Verification
REQ-029 Op 10, N=2, {1,2} -> tx 03 00 00 00, err_o never high.
REQ-030 Op 11, N=2, {5,6} -> 1E 00 00 00; op 11 {32'h0001_0000, 32'h0001_0000} -> 00 00 00 00.
REQ-031 Op 22, N=2, any operands -> FF FF FF FF, one err_o pulse; N=0 any opcode -> 00 00 00 00 plus err_o pulse.
REQ-032 Op 10, N=3, {FFFF_FFFF, 1, 5}, tx_ready_i low 10 cycles per byte -> 05 00 00 00, tx_data_o stable while stalled.
REQ-033 Stop after 2 operand bytes for TIMEOUT_CYCLES -> err_o pulse, no tx, next packet {1,2} op 10 -> 03 00 00 00.
REQ-034 Assert rst_ni low during mul EXEC -> all outputs at reset values, no tx bytes; next add packet correct.
